// File: rtl/rom_fetch_sequencer.sv
// Program-counter / control-flow sequencer driving the instruction ROM address.
// Handles sequential fetch, jumps, branches, CALL/RET via a return stack, and delay NOPs.
module rom_fetch_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int TARGET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8,
  parameter int WAIT_WIDTH   = 24
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iStall,
  input  logic                          iJump,
  input  logic                          iBranchTaken,
  input  logic                          iCall,
  input  logic                          iRet,
  input  logic                          iWait,
  input  logic [TARGET_WIDTH-1:0]       iTarget,
  input  logic [WAIT_WIDTH-1:0]         iWaitCycles,
  output logic [ADDR_WIDTH-1:0]         oAddress,
  output logic                          oValid,
  output logic [$clog2(STACK_DEPTH):0]  oDepth,
  output logic                          oError
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RUN_PEND = 2'd0,
    RUN      = 2'd1,
    WAIT     = 2'd2,
    ERR      = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    vld_nxt;
  logic [DEPTH_W-1:0]      depth_nxt;
  logic                    err_nxt;
  logic [WAIT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    push;

  logic [ADDR_WIDTH-1:0]   stack [STACK_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0]   addr_inc, target_ext;
  logic                    stack_full, stack_empty;

  assign wr_ptr      = oDepth[PTR_W-1:0];
  assign rd_ptr      = wr_ptr - PTR_W'(1);
  assign addr_inc    = oAddress + ADDR_WIDTH'(1);
  assign target_ext  = ADDR_WIDTH'(iTarget);
  assign stack_full  = (oDepth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (oDepth == '0);

  always_comb begin
    state_nxt = state;
    addr_nxt  = oAddress;
    vld_nxt   = 1'b0;
    depth_nxt = oDepth;
    err_nxt   = oError;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      RUN_PEND: begin
        state_nxt = RUN;
        vld_nxt   = 1'b1;
      end
      RUN: begin
        // A stalled core re-presents its strobes later, so nothing is acted on here.
        if (!iStall) begin
          vld_nxt = 1'b1;
          if (iRet) begin
            if (stack_empty) begin
              state_nxt = ERR;
              err_nxt   = 1'b1;
              vld_nxt   = 1'b0;
            end else begin
              addr_nxt  = stack[rd_ptr];
              depth_nxt = oDepth - DEPTH_W'(1);
            end
          end else if (iCall) begin
            if (stack_full) begin
              state_nxt = ERR;
              err_nxt   = 1'b1;
              vld_nxt   = 1'b0;
            end else begin
              push      = 1'b1;
              depth_nxt = oDepth + DEPTH_W'(1);
              addr_nxt  = target_ext;
            end
          end else if (iJump || iBranchTaken) begin
            addr_nxt = target_ext;
          end else if (iWait && (iWaitCycles != '0)) begin
            cnt_nxt   = iWaitCycles;
            state_nxt = WAIT;
            vld_nxt   = 1'b0;
          end else begin
            addr_nxt = addr_inc;
          end
        end
      end
      WAIT: begin
        // Advancing on the final decrement gives an N+1 cycle gap between instructions.
        if (cnt == WAIT_WIDTH'(1)) begin
          cnt_nxt   = '0;
          addr_nxt  = addr_inc;
          vld_nxt   = 1'b1;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - WAIT_WIDTH'(1);
        end
      end
      ERR: begin
        vld_nxt = 1'b0;
      end
      default: begin
        state_nxt = ERR;
        err_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= RUN_PEND;
      oAddress <= '0;
      oValid   <= 1'b0;
      oDepth   <= '0;
      oError   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      oAddress <= addr_nxt;
      oValid   <= vld_nxt;
      oDepth   <= depth_nxt;
      oError   <= err_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Stack storage is not reset; only the occupancy pointer is.
  always_ff @(posedge Clock) begin
    if (push) stack[wr_ptr] <= addr_inc;
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Self-checking bench for rom_fetch_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_rom_fetch_sequencer;

  localparam int AW = 16;
  localparam int TW = 8;
  localparam int SD = 8;
  localparam int WW = 24;

  logic           Clock = 1'b0;
  logic           Reset, iStall, iJump, iBranchTaken, iCall, iRet, iWait;
  logic [TW-1:0]  iTarget;
  logic [WW-1:0]  iWaitCycles;
  logic [AW-1:0]  oAddress;
  logic           oValid;
  logic [3:0]     oDepth;
  logic           oError;
  logic [8:0]     nAddress;
  logic           nValid;
  logic [3:0]     nDepth;
  logic           nError;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  rom_fetch_sequencer #(.ADDR_WIDTH(AW), .TARGET_WIDTH(TW), .STACK_DEPTH(SD), .WAIT_WIDTH(WW)) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iJump(iJump), .iBranchTaken(iBranchTaken),
    .iCall(iCall), .iRet(iRet), .iWait(iWait), .iTarget(iTarget), .iWaitCycles(iWaitCycles),
    .oAddress(oAddress), .oValid(oValid), .oDepth(oDepth), .oError(oError)
  );

  // Narrow-address copy so the wrap-around is reachable in a few hundred cycles.
  rom_fetch_sequencer #(.ADDR_WIDTH(9), .TARGET_WIDTH(TW), .STACK_DEPTH(SD), .WAIT_WIDTH(WW)) narrow (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iJump(iJump), .iBranchTaken(iBranchTaken),
    .iCall(iCall), .iRet(iRet), .iWait(iWait), .iTarget(iTarget), .iWaitCycles(iWaitCycles),
    .oAddress(nAddress), .oValid(nValid), .oDepth(nDepth), .oError(nError)
  );

  typedef struct {
    int rst, stall, jmp, br, call, ret, wt, tgt, wc;
    int ea, ev, ed, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int stall, int jmp, int br, int call, int ret, int wt,
                              int tgt, int wc, int ea, int ev, int ed, int ee);
    vec_t r;
    r.rst = rst; r.stall = stall; r.jmp = jmp; r.br = br; r.call = call; r.ret = ret;
    r.wt = wt; r.tgt = tgt; r.wc = wc; r.ea = ea; r.ev = ev; r.ed = ed; r.ee = ee;
    return r;
  endfunction

  task automatic drive(int rst, int stall, int jmp, int br, int call, int ret, int wt, int tgt, int wc);
    Reset        = (rst != 0);
    iStall       = (stall != 0);
    iJump        = (jmp != 0);
    iBranchTaken = (br != 0);
    iCall        = (call != 0);
    iRet         = (ret != 0);
    iWait        = (wt != 0);
    iTarget      = TW'(tgt);
    iWaitCycles  = WW'(wc);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_main(string nm, int ea, int ev, int ed, int ee);
    logic [21:0] act, exp;
    act = {oAddress, oValid, oDepth, oError};
    exp = {AW'(ea), 1'(ev), 4'(ed), 1'(ee)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got addr=%0d valid=%0b depth=%0d err=%0b, want addr=%0d valid=%0d depth=%0d err=%0d",
               nm, oAddress, oValid, oDepth, oError, ea, ev, ed, ee);
    end
  endtask

  task automatic chk_narrow(string nm, int ea, int ev);
    checks++;
    if ({nAddress, nValid} !== {9'(ea), 1'(ev)}) begin
      errors++;
      $display("FAIL %s: got addr=%0d valid=%0b, want addr=%0d valid=%0d", nm, nAddress, nValid, ea, ev);
    end
  endtask

  // Reference model: program counter as an integer, return stack as a queue.
  int m_addr, m_valid, m_err, m_pend, m_wait;
  int stk[$];

  task automatic model_step(int rst, int stall, int jmp, int br, int call, int ret, int wt, int tgt, int wc);
    if (rst != 0) begin
      m_addr = 0; m_valid = 0; m_err = 0; m_pend = 1; m_wait = 0;
      stk.delete();
      return;
    end
    m_valid = 0;
    if (m_err != 0) return;
    if (m_pend != 0) begin
      m_pend = 0; m_valid = 1;
      return;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_addr = (m_addr + 1) % 65536; m_valid = 1;
      end
      return;
    end
    if (stall != 0) return;
    m_valid = 1;
    if (ret != 0) begin
      if (stk.size() == 0) begin m_err = 1; m_valid = 0; end
      else m_addr = stk.pop_back();
    end else if (call != 0) begin
      if (stk.size() == SD) begin m_err = 1; m_valid = 0; end
      else begin stk.push_back((m_addr + 1) % 65536); m_addr = tgt; end
    end else if (jmp != 0 || br != 0) begin
      m_addr = tgt;
    end else if (wt != 0 && wc != 0) begin
      m_wait = wc; m_valid = 0;
    end else begin
      m_addr = (m_addr + 1) % 65536;
    end
  endtask

  initial begin
    idle();
    //            rst stl jmp br cal ret wt  tgt  wc   addr v d e
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 0,    0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,    0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,    1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,    2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,    3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   9, 0,    9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 100, 0,  100, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 118, 0,  118, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0,   10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,   11, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,   12, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,  60, 0,   60, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 200, 0,  200, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,  77, 0,   61, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  29, 0,   29, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 4,   29, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0,   5, 0,   29, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0, 0,   29, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,   29, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,   30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  29, 0,   29, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0,   30, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 0,   30, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,   31, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 255, 0,  255, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  256, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 1,  256, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0,  257, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].jmp, tbl[i].br, tbl[i].call, tbl[i].ret,
            tbl[i].wt, tbl[i].tgt, tbl[i].wc);
      tick();
      chk_main($sformatf("vec[%0d]", i), tbl[i].ea, tbl[i].ev, tbl[i].ed, tbl[i].ee);
    end

    // Overflow on the ninth nested call, then frozen until reset.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("ovf_reset", 0, 0, 0, 0);
    idle(); tick(); chk_main("ovf_pend", 0, 1, 0, 0);
    for (int i = 0; i < SD; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 10 + i, 0); tick();
      chk_main($sformatf("call[%0d]", i), 10 + i, 1, i + 1, 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 50, 0); tick(); chk_main("ovf_call9", 17, 0, 8, 1);
    drive(0, 0, 1, 0, 0, 0, 0, 3, 0); tick(); chk_main("ovf_frozen", 17, 0, 8, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick(); chk_main("ovf_ret_ignored", 17, 0, 8, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("ovf_cleared", 0, 0, 0, 0);

    // Underflow straight after reset, then reset in the middle of a wait.
    idle(); tick(); chk_main("udf_pend", 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick(); chk_main("udf_ret", 0, 0, 0, 1);
    idle(); tick(); chk_main("udf_frozen", 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("udf_cleared", 0, 0, 0, 0);
    idle(); tick(); chk_main("mw_pend", 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 10); tick(); chk_main("mw_start", 0, 0, 0, 0);
    idle(); tick(); chk_main("mw_waiting", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick(); chk_main("mw_reset", 0, 0, 0, 0);
    idle(); tick(); chk_main("mw_pend_again", 0, 1, 0, 0);
    idle(); tick(); chk_main("mw_run", 1, 1, 0, 0);

    // Address wrap on the narrow instance, then a stall with a jump held.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 255, 0); tick(); chk_narrow("wrap_jump", 255, 1);
    idle();
    for (int i = 0; i < 256; i++) tick();
    chk_narrow("wrap_top", 511, 1);
    chk_main("wide_top", 511, 1, 0, 0);
    tick();
    chk_narrow("wrap_zero", 0, 1);
    chk_main("wide_no_wrap", 512, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 99, 0); tick();
      chk_main($sformatf("stall[%0d]", i), 512, 0, 0, 0);
      chk_narrow($sformatf("nstall[%0d]", i), 0, 0);
    end
    idle(); tick();
    chk_main("stall_release", 513, 1, 0, 0);
    chk_narrow("nstall_release", 1, 1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int rst, stall, jmp, br, call, ret, wt, tgt, wc;
      if (c == 0) rst = 1;
      else if (m_err != 0) rst = ($urandom_range(3) == 0) ? 1 : 0;
      else rst = ($urandom_range(199) == 0) ? 1 : 0;
      stall = ($urandom_range(7) == 0) ? 1 : 0;
      jmp   = ($urandom_range(9) == 0) ? 1 : 0;
      br    = ($urandom_range(9) == 0) ? 1 : 0;
      call  = ($urandom_range(5) == 0) ? 1 : 0;
      ret   = ($urandom_range(6) == 0) ? 1 : 0;
      wt    = ($urandom_range(9) == 0) ? 1 : 0;
      tgt   = int'($urandom_range(255));
      wc    = int'($urandom_range(6));
      drive(rst, stall, jmp, br, call, ret, wt, tgt, wc);
      model_step(rst, stall, jmp, br, call, ret, wt, tgt, wc);
      tick();
      chk_main($sformatf("rand[%0d]", c), m_addr, m_valid, stk.size(), m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
Program-counter and control-flow sequencer that drives the instruction ROM address for the lab CPU.
- Computes the next fetch address from decoded control strobes: sequential, JMP, taken BLE/BGE, CALL and RET.
- Keeps a hardware return-address stack for CALL/RET.
- Provides a programmable wait counter for delay NOPs and stall handling from the core.
- Sits between the instruction decoder and the ROM iAddress input.

Parameters:
ADDR_WIDTH, 16, width of the ROM address / program counter.
TARGET_WIDTH, 8, width of branch/call target field; zero-extended to ADDR_WIDTH.
STACK_DEPTH, 8, return-address stack entries (power of two).
WAIT_WIDTH, 24, width of the delay count field.

Ports:
Clock  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
iStall  input  1  core not ready; hold current address.
iJump  input  1  unconditional jump to iTarget.
iBranchTaken  input  1  conditional branch resolved taken; go to iTarget.
iCall  input  1  push return address, go to iTarget.
iRet  input  1  pop return address.
iWait  input  1  start delay of iWaitCycles cycles.
iTarget  input  TARGET_WIDTH  jump/branch/call destination.
iWaitCycles  input  WAIT_WIDTH  delay length in cycles.
oAddress  output  ADDR_WIDTH  ROM address (registered).
oValid  output  1  instruction at oAddress is to be executed this cycle.
oDepth  output  log2(STACK_DEPTH)+1  current stack occupancy.
oError  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (sampled high at an edge):
  - oAddress=0, oValid=0, oDepth=0, oError=0.
  - Wait counter=0, state=RUN_PEND.
- States:
  - RUN_PEND: one cycle after reset with oValid=0, then RUN with oAddress=0, oValid=1.
  - RUN: normal fetch.
  - WAIT: delay in progress.
  - ERR: terminal until reset.
- RUN, iStall=1:
  - oAddress held, oValid=0.
  - All control strobes ignored; the decoder re-presents them after the stall.
- RUN, iStall=0: next-address priority is iRet > iCall > iJump > iBranchTaken > iWait > sequential.
  - Next address appears on oAddress one cycle later, with oValid=1. Single-cycle fetch latency.
  - Sequential: oAddress+1, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
  - iJump / iBranchTaken: oAddress <= zero-extended iTarget.
  - iCall with oDepth<STACK_DEPTH: push oAddress+1 (wrapped), oDepth+1, oAddress <= iTarget.
  - iCall with oDepth==STACK_DEPTH: overflow. Go to ERR, oError=1, no push.
  - iRet with oDepth>0: oAddress <= top entry, oDepth-1.
  - iRet with oDepth==0: underflow. Go to ERR, oError=1.
  - iWait with iWaitCycles=0: same as sequential.
  - iWait with iWaitCycles=N>0: load counter=N, go to WAIT.
- WAIT:
  - oValid=0, oAddress held; all strobes and iStall ignored.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0, oAddress <= oAddress+1 and state=RUN. oValid=1 on the next cycle.
  - Total gap between instruction and successor: N+1 cycles.
- ERR:
  - oValid=0, oAddress frozen at its last value, oError=1.
  - Only Reset exits.
- Stack:
  - LIFO with register storage. Push and pop never occur together (priority rule).
  - Stack contents need not be cleared on reset; only the pointer is cleared.
- Reset mid-WAIT or mid-stall: reset wins, full reset values apply at that edge.
- Target zero-extension: upper ADDR_WIDTH-TARGET_WIDTH bits are 0. Sequential fetch may still exceed 255.

Test Plan:
1. Reset then 5 free-running cycles, no strobes -> oValid 0 for one cycle; then oAddress 0,1,2,3 with oValid=1.
2. At oAddress=9, pulse iCall with iTarget=100 -> oAddress=100, oDepth=1. At 118, pulse iRet -> oAddress=10, oDepth=0.
3. At oAddress=12, assert iBranchTaken and iJump, iTarget=60; separately assert iRet and iCall together at depth 1 -> first gives 60; second pops (iRet priority), depth 0.
4. At oAddress=29, iWait with iWaitCycles=4 -> oValid low for 4 cycles, oAddress 29 held, then 30 with oValid=1. Strobes injected during WAIT are ignored. Also iWaitCycles=0 -> next address 30 immediately.
5. Nine nested calls with STACK_DEPTH=8 -> 9th call sets oError=1, oValid=0, oAddress frozen. Separately, iRet at depth 0 after reset -> oError=1. Reset clears both cases.
6. Preload oAddress 0xFFFF via sequential run or jump chain, then one sequential step -> oAddress=0x0000. iStall held 3 cycles with iJump asserted -> address unchanged, jump not taken.
